conv_layer_sequencer: RTL

Controller for the 1x4x3x3 convolution/accumulate/quantise/ReLU/max-pool datapath. It loads a layer's configuration from a byte stream into holding registers: 36 weights, 4 input zero points, the shift, the output zero point and the ReLU zero point. It then streams one frame of 4-channel pixels into the datapath and counts the pooled results until the frame is complete. It sits between the layer-level DMA/scheduler and the datapath, and owns the datapath's valid_in and all of its static configuration inputs.

---
 rtl/conv_layer_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_sequencer.sv
// Layer controller for the 4-channel 3x3 conv/quantise/ReLU/pool datapath: loads the
// layer configuration from a byte stream, streams one frame of pixels, counts pooled results.
module conv_layer_sequencer #(
  parameter int IMG_W         = 128,
  parameter int IMG_H         = 128,
  parameter int OUT_COUNT     = 3969,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         reuse_cfg,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         err_timeout,
  output logic         cfg_loaded,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [7:0]   cfg_data,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [31:0]  pix_data,
  output logic         conv_valid_in,
  output logic [31:0]  conv_din,
  output logic [287:0] conv_weights,
  output logic [31:0]  conv_zero_points,
  output logic [3:0]   conv_shift,
  output logic [7:0]   conv_zp_z3,
  output logic [7:0]   conv_relu_zp,
  input  logic         dp_valid_out,
  input  logic [7:0]   dp_dout,
  output logic         out_valid,
  output logic [7:0]   out_data,
  output logic [11:0]  out_cnt
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NPIX - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(DRAIN_TIMEOUT);
  localparam logic [11:0]      OUT_LIMIT = 12'(OUT_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CFG,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         cfg_idx_q, cfg_idx_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [11:0]        out_cnt_q, out_cnt_d;
  logic [287:0]       weights_q, weights_d;
  logic [31:0]        zp_q, zp_d;
  logic [3:0]         shift_q, shift_d;
  logic [7:0]         zp_z3_q, zp_z3_d;
  logic [7:0]         relu_zp_q, relu_zp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cfg_loaded_q, cfg_loaded_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               pix_ready_q, pix_ready_d;
  logic               conv_valid_q, conv_valid_d;
  logic [31:0]        conv_din_q, conv_din_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;

  logic cfg_acc;
  logic pix_acc;
  logic fwd;

  always_comb begin
    state_d      = state_q;
    cfg_idx_d    = cfg_idx_q;
    pix_cnt_d    = pix_cnt_q;
    tmo_d        = tmo_q;
    out_cnt_d    = out_cnt_q;
    weights_d    = weights_q;
    zp_d         = zp_q;
    shift_d      = shift_q;
    zp_z3_d      = zp_z3_q;
    relu_zp_d    = relu_zp_q;
    err_d        = err_q;
    cfg_loaded_d = cfg_loaded_q;
    conv_din_d   = conv_din_q;
    out_data_d   = out_data_q;
    conv_valid_d = 1'b0;
    out_valid_d  = 1'b0;

    cfg_acc = (state_q == S_LOAD_CFG) && cfg_valid && cfg_ready_q;
    pix_acc = (state_q == S_STREAM) && pix_valid && pix_ready_q;
    fwd     = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && dp_valid_out;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pix_cnt_d = '0;
          out_cnt_d = '0;
          tmo_d     = '0;
          err_d     = 1'b0;
          cfg_idx_d = '0;
          if (reuse_cfg && cfg_loaded_q) begin
            state_d = S_STREAM;
          end else begin
            state_d      = S_LOAD_CFG;
            cfg_loaded_d = 1'b0;
          end
        end
      end
      S_LOAD_CFG: begin
        if (cfg_acc) begin
          // Byte map: 0-35 weights, 36-39 input zero points, 40 shift, 41 zp_z3, 42 relu_zp
          for (int k = 0; k < 36; k++) begin
            if (cfg_idx_q == 6'(k)) weights_d[k*8 +: 8] = cfg_data;
          end
          for (int k = 0; k < 4; k++) begin
            if (cfg_idx_q == 6'(36 + k)) zp_d[k*8 +: 8] = cfg_data;
          end
          if (cfg_idx_q == 6'd40) shift_d   = cfg_data[3:0];
          if (cfg_idx_q == 6'd41) zp_z3_d   = cfg_data;
          if (cfg_idx_q == 6'd42) relu_zp_d = cfg_data;
          cfg_idx_d = cfg_idx_q + 6'd1;
          if (cfg_idx_q == 6'd42) begin
            cfg_loaded_d = 1'b1;
            state_d      = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (pix_acc) begin
          conv_valid_d = 1'b1;
          conv_din_d   = pix_data;
          pix_cnt_d    = pix_cnt_q + 1'b1;
          if (pix_cnt_q == LAST_PIX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dp_valid_out) begin
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The count can complete while pixels are still streaming; that ends the frame early.
    if (fwd) begin
      out_valid_d = 1'b1;
      out_data_d  = dp_dout;
      out_cnt_d   = out_cnt_q + 12'd1;
      if (out_cnt_d == OUT_LIMIT) state_d = S_DONE;
    end

    // Abort wins over everything: nothing accepted or forwarded in this cycle takes effect.
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      conv_valid_d = 1'b0;
      out_valid_d  = 1'b0;
      cfg_idx_d    = cfg_idx_q;
      pix_cnt_d    = pix_cnt_q;
      tmo_d        = tmo_q;
      out_cnt_d    = out_cnt_q;
      weights_d    = weights_q;
      zp_d         = zp_q;
      shift_d      = shift_q;
      zp_z3_d      = zp_z3_q;
      relu_zp_d    = relu_zp_q;
      err_d        = err_q;
      conv_din_d   = conv_din_q;
      out_data_d   = out_data_q;
      cfg_loaded_d = (state_q == S_LOAD_CFG) ? 1'b0 : cfg_loaded_q;
    end

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cfg_ready_d = (state_d == S_LOAD_CFG);
    pix_ready_d = (state_d == S_STREAM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cfg_idx_q    <= '0;
      pix_cnt_q    <= '0;
      tmo_q        <= '0;
      out_cnt_q    <= '0;
      weights_q    <= '0;
      zp_q         <= '0;
      shift_q      <= '0;
      zp_z3_q      <= '0;
      relu_zp_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cfg_loaded_q <= 1'b0;
      cfg_ready_q  <= 1'b0;
      pix_ready_q  <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_din_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_idx_q    <= cfg_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      tmo_q        <= tmo_d;
      out_cnt_q    <= out_cnt_d;
      weights_q    <= weights_d;
      zp_q         <= zp_d;
      shift_q      <= shift_d;
      zp_z3_q      <= zp_z3_d;
      relu_zp_q    <= relu_zp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cfg_loaded_q <= cfg_loaded_d;
      cfg_ready_q  <= cfg_ready_d;
      pix_ready_q  <= pix_ready_d;
      conv_valid_q <= conv_valid_d;
      conv_din_q   <= conv_din_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err_timeout      = err_q;
  assign cfg_loaded       = cfg_loaded_q;
  assign cfg_ready        = cfg_ready_q;
  assign pix_ready        = pix_ready_q;
  assign conv_valid_in    = conv_valid_q;
  assign conv_din         = conv_din_q;
  assign conv_weights     = weights_q;
  assign conv_zero_points = zp_q;
  assign conv_shift       = shift_q;
  assign conv_zp_z3       = zp_z3_q;
  assign conv_relu_zp     = relu_zp_q;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_cnt          = out_cnt_q;

endmodule
